// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source for the video switch input side.
// Generates pixel strobe, hsync/vsync, blanking and an 8-bar colour pattern
// on clk32 in NTSC or PAL geometry. Outputs are registered from the raster
// position on the strobe cycle, so they all change one clk32 after ce_pix.
// Optional interlace support: define VIDEO_TIMING_GEN_INTERLACE_EN.
module video_timing_gen #(
  parameter int CE_DIV       = 4,
  parameter int H_TOTAL_NTSC = 520,
  parameter int H_TOTAL_PAL  = 504,
  parameter int V_TOTAL_NTSC = 263,
  parameter int V_TOTAL_PAL  = 312,
  parameter int H_ACTIVE     = 400,
  parameter int HSYNC_START  = 420,
  parameter int HSYNC_LEN    = 38,
  parameter int V_ACTIVE     = 234,
  parameter int VSYNC_START  = 250,
  parameter int VSYNC_LEN    = 3
) (
  input  logic       clk32,
  input  logic       reset_n,
  input  logic       ntsc,
  input  logic       pause,
  input  logic       ilace,
  output logic       ce_pix,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       ilace_out,
  output logic       field,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam int CE_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [CE_W-1:0] CE_LAST = CE_W'(CE_DIV - 1);

  localparam logic [9:0] HT_N  = 10'(H_TOTAL_NTSC);
  localparam logic [9:0] HT_P  = 10'(H_TOTAL_PAL);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] HS_S  = 10'(HSYNC_START);
  localparam logic [9:0] HS_E  = 10'(HSYNC_START + HSYNC_LEN);
  localparam logic [8:0] VT_N  = 9'(V_TOTAL_NTSC);
  localparam logic [8:0] VT_P  = 9'(V_TOTAL_PAL);
  localparam logic [8:0] V_ACT = 9'(V_ACTIVE);
  localparam logic [8:0] VS_S  = 9'(VSYNC_START);
  localparam logic [8:0] VS_E  = 9'(VSYNC_START + VSYNC_LEN);

  // Geometry must fit the 10-bit/9-bit counters and keep sync inside the
  // shortest frame (NTSC odd field is one line short when interlaced).
  if (CE_DIV < 2 || (CE_DIV & (CE_DIV - 1)) != 0) begin : g_bad_ce_div
    $error("video_timing_gen: CE_DIV must be a power of 2 and >= 2");
  end
  if (H_TOTAL_NTSC > 1023 || H_TOTAL_PAL > 1023) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL exceeds 10-bit counter");
  end
  if (V_TOTAL_NTSC > 511 || V_TOTAL_PAL + 1 > 511) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL exceeds 9-bit counter");
  end
  if (HSYNC_START + HSYNC_LEN > H_TOTAL_NTSC || HSYNC_START + HSYNC_LEN > H_TOTAL_PAL ||
      H_ACTIVE > H_TOTAL_NTSC || H_ACTIVE > H_TOTAL_PAL) begin : g_bad_h_window
    $error("video_timing_gen: horizontal windows outside line total");
  end
  if (VSYNC_START + VSYNC_LEN > V_TOTAL_NTSC - 1 || VSYNC_START + VSYNC_LEN > V_TOTAL_PAL ||
      V_ACTIVE > V_TOTAL_NTSC - 1 || V_ACTIVE > V_TOTAL_PAL) begin : g_bad_v_window
    $error("video_timing_gen: vertical windows outside frame total");
  end

  logic [CE_W-1:0] cediv;
  logic [9:0]      hcnt;
  logic [8:0]      vcnt;
  logic            mode_r;
  logic            ilace_r;
  logic            field_r;

  logic            vld_p0;
  logic [9:0]      h_total_p0;
  logic [8:0]      v_total_p0;
  logic            h_last_p0;
  logic            v_last_p0;
  logic            hsync_p0;
  logic            vsync_p0;
  logic            hblank_p0;
  logic            vblank_p0;
  logic            blank_p0;
  logic [2:0]      bar_p0;
`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
  logic [9:0]      h_half_p0;
`else
  logic            unused_ilace;
  assign unused_ilace = ilace;
`endif

  assign ce_pix = vld_p0;

  // Stage 0: decode the current raster position into next output values.
  always_comb begin
    vld_p0     = (cediv == CE_LAST) && !pause;
    h_total_p0 = mode_r ? HT_N : HT_P;
    v_total_p0 = mode_r ? VT_N : VT_P;
`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
    h_half_p0  = {1'b0, h_total_p0[9:1]};
    if (ilace_r && field_r) begin
      v_total_p0 = mode_r ? (VT_N - 9'd1) : (VT_P + 9'd1);
    end
`endif
    h_last_p0  = (hcnt == h_total_p0 - 10'd1);
    v_last_p0  = (vcnt == v_total_p0 - 9'd1);
    hblank_p0  = (hcnt >= H_ACT);
    vblank_p0  = (vcnt >= V_ACT);
    blank_p0   = hblank_p0 || vblank_p0;
    hsync_p0   = (hcnt >= HS_S) && (hcnt < HS_E);
    vsync_p0   = (vcnt >= VS_S) && (vcnt < VS_E);
`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
    // Odd field: vsync edges move half a line later.
    if (field_r) begin
      vsync_p0 = ((vcnt > VS_S) || ((vcnt == VS_S) && (hcnt >= h_half_p0))) &&
                 ((vcnt < VS_E) || ((vcnt == VS_E) && (hcnt < h_half_p0)));
    end
`endif
    bar_p0     = hcnt[8:6];
  end

  // Strobe divider and raster counters; geometry and interlace latch at frame start.
  // Interlace starts inactive after reset and is picked up at the first frame start.
  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      cediv   <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
      mode_r  <= ntsc;
      ilace_r <= 1'b0;
      field_r <= 1'b0;
    end else if (!pause) begin
      cediv <= cediv + 1'b1;
      if (vld_p0) begin
        if (h_last_p0) begin
          hcnt <= '0;
          if (v_last_p0) begin
            vcnt   <= '0;
            mode_r <= ntsc;
`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
            ilace_r <= ilace;
            field_r <= ilace & ~field_r;
`else
            ilace_r <= 1'b0;
            field_r <= 1'b0;
`endif
          end else begin
            vcnt <= vcnt + 9'd1;
          end
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  // Stage 1: register all outputs together from the strobe-cycle position.
  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      hblank    <= 1'b0;
      vblank    <= 1'b0;
      ilace_out <= 1'b0;
      field     <= 1'b0;
      r         <= 8'h00;
      g         <= 8'h00;
      b         <= 8'h00;
    end else if (vld_p0) begin
      hsync     <= hsync_p0;
      vsync     <= vsync_p0;
      hblank    <= hblank_p0;
      vblank    <= vblank_p0;
      ilace_out <= ilace_r;
      field     <= field_r;
      r         <= blank_p0 ? 8'h00 : {8{bar_p0[2]}};
      g         <= blank_p0 ? 8'h00 : {8{bar_p0[1]}};
      b         <= blank_p0 ? 8'h00 : {8{bar_p0[0]}};
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: self-checking bench for video_timing_gen using a
// reduced raster geometry so whole frames fit a short run. A pixel model
// pushes expected outputs on each predicted strobe; they are popped and
// compared the following cycle. Directed steps check periods and edges.
module tb_video_timing_gen;

  localparam int CE_DIV = 4;
  localparam int HTN    = 160;
  localparam int HTP    = 144;
  localparam int VTN    = 13;
  localparam int VTP    = 16;
  localparam int HA     = 136;
  localparam int HSS    = 140;
  localparam int HSL    = 8;
  localparam int VA     = 8;
  localparam int VSS    = 9;
  localparam int VSL    = 2;
`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
  localparam int IL_EN  = 1;
`else
  localparam int IL_EN  = 0;
`endif

  localparam int S_HSYNC = 0, S_VSYNC = 1, S_HBLANK = 2, S_VBLANK = 3, S_CE = 4;

  logic       clk32 = 1'b0;
  logic       reset_n = 1'b0;
  logic       ntsc = 1'b1;
  logic       pause = 1'b0;
  logic       ilace = 1'b0;
  logic       ce_pix, hsync, vsync, hblank, vblank, ilace_out, field;
  logic [7:0] r, g, b;
  logic [29:0] obs_vec;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  assign obs_vec = {hsync, vsync, hblank, vblank, ilace_out, field, r, g, b};

  always #5 clk32 = ~clk32;
  always @(posedge clk32) cyc <= cyc + 1;

  video_timing_gen #(
    .CE_DIV(CE_DIV), .H_TOTAL_NTSC(HTN), .H_TOTAL_PAL(HTP),
    .V_TOTAL_NTSC(VTN), .V_TOTAL_PAL(VTP), .H_ACTIVE(HA),
    .HSYNC_START(HSS), .HSYNC_LEN(HSL), .V_ACTIVE(VA),
    .VSYNC_START(VSS), .VSYNC_LEN(VSL)
  ) dut (
    .clk32(clk32), .reset_n(reset_n), .ntsc(ntsc), .pause(pause), .ilace(ilace),
    .ce_pix(ce_pix), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .ilace_out(ilace_out), .field(field), .r(r), .g(g), .b(b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      S_HSYNC:  return hsync;
      S_VSYNC:  return vsync;
      S_HBLANK: return hblank;
      S_VBLANK: return vblank;
      default:  return ce_pix;
    endcase
  endfunction

  // Bounded wait for a transition of the selected output to lvl, sampled on negedges.
  task automatic wait_edge(input int sel, input logic lvl, input int limit, input string tag);
    logic prev, cur;
    bit   found;
    found = 1'b0;
    prev  = get_sig(sel);
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk32);
      cur = get_sig(sel);
      if (cur == lvl && prev != lvl) found = 1'b1;
      prev = cur;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Expected registered outputs for pixel (h, v), computed from linear frame position.
  function automatic logic [29:0] expect_px(input int h, input int v, input bit mode,
                                            input bit il, input bit fld);
    int ht, pos, vs0, vs1;
    logic hs, vs, hb, vb;
    logic [2:0] idx;
    logic [7:0] rr, gg, bb;
    ht  = mode ? HTN : HTP;
    pos = v * ht + h;
    vs0 = VSS * ht;
    vs1 = (VSS + VSL) * ht;
    if (fld) begin
      vs0 += ht / 2;
      vs1 += ht / 2;
    end
    hs  = (h >= HSS) && (h < HSS + HSL);
    vs  = (pos >= vs0) && (pos < vs1);
    hb  = (h >= HA);
    vb  = (v >= VA);
    idx = 3'(h / 64);
    rr  = (hb || vb) ? 8'h00 : {8{idx[2]}};
    gg  = (hb || vb) ? 8'h00 : {8{idx[1]}};
    bb  = (hb || vb) ? 8'h00 : {8{idx[0]}};
    return {hs, vs, hb, vb, il, fld, rr, gg, bb};
  endfunction

  logic [29:0] sb_q[$];
  logic [29:0] last_exp = '0;
  bit          m_run = 1'b0;
  int          m_div, m_h, m_v;
  bit          m_mode, m_il, m_field;

  // Scoreboard: compare outputs and strobe every cycle, then advance the pixel model.
  always @(negedge clk32) begin
    bit exp_ce;
    int vt;
    if (m_run) begin
      if (sb_q.size() > 0) last_exp = sb_q.pop_front();
      check("outputs", 32'(obs_vec), 32'(last_exp));
      exp_ce = (m_div == CE_DIV - 1) && !pause;
      check("ce_pix", 32'(ce_pix), 32'(exp_ce));
    end
    if (!reset_n) begin
      m_run = 1'b1; m_div = 0; m_h = 0; m_v = 0;
      m_mode = ntsc; m_il = 1'b0; m_field = 1'b0;
      sb_q.delete();
      sb_q.push_back('0);
    end else if (m_run && !pause) begin
      if (m_div == CE_DIV - 1) begin
        sb_q.push_back(expect_px(m_h, m_v, m_mode, m_il, m_field));
        m_h++;
        if (m_h == (m_mode ? HTN : HTP)) begin
          m_h = 0;
          m_v++;
          if (m_mode) vt = (m_il && m_field) ? VTN - 1 : VTN;
          else        vt = (m_il && m_field) ? VTP + 1 : VTP;
          if (m_v == vt) begin
            m_v = 0;
            m_mode = ntsc;
`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
            m_field = ilace ? ~m_field : 1'b0;
            m_il = ilace;
`endif
          end
        end
      end
      m_div = (m_div + 1) % CE_DIV;
    end
  end

  initial begin
    repeat (95000) @(posedge clk32);
    $display("FAIL watchdog cycles=%0d limit=95000", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned t_a, t_b, t_c, t_v, t_n, t_w, t0;
    logic [29:0] snap;

    // Step 1: reset for three cycles, then first strobe and strobe period.
    reset_n = 1'b0; ntsc = 1'b1; pause = 1'b0; ilace = 1'b0;
    repeat (3) @(posedge clk32);
    #1;
    check("reset_outputs", 32'({ce_pix, obs_vec}), 32'd0);
    reset_n = 1'b1;
    t0 = cyc;
    wait_edge(S_CE, 1'b1, 20, "first_ce_seen");
    check("first_ce_cycle", cyc - t0 + 1, 32'd4);
    t0 = cyc;
    wait_edge(S_CE, 1'b1, 20, "second_ce_seen");
    check("ce_period", cyc - t0, 32'(CE_DIV));

    // Step 2: free-running NTSC hsync and vsync timing.
    wait_edge(S_HSYNC, 1'b1, 2000, "hsync_align");
    t0 = cyc;
    wait_edge(S_HSYNC, 1'b0, 2000, "hsync_fall");
    check("hsync_width", cyc - t0, 32'(HSL * CE_DIV));
    wait_edge(S_HSYNC, 1'b1, 2000, "hsync_rise");
    check("hsync_period", cyc - t0, 32'(HTN * CE_DIV));
    wait_edge(S_VSYNC, 1'b1, 20000, "vsync_align");
    t0 = cyc;
    wait_edge(S_VSYNC, 1'b0, 20000, "vsync_fall");
    check("vsync_width", cyc - t0, 32'(VSL * HTN * CE_DIV));
    wait_edge(S_VSYNC, 1'b1, 20000, "vsync_rise");
    check("vsync_period_ntsc", cyc - t0, 32'(VTN * HTN * CE_DIV));
    t_a = cyc;

    // Step 3: switch to PAL mid-frame; current NTSC frame completes first.
    @(posedge clk32); #1;
    ntsc = 1'b0;
    wait_edge(S_VSYNC, 1'b1, 20000, "vsync_pal_rise");
    t_b = cyc;
    check("ntsc_to_pal_span", t_b - t_a, 32'((VTN - VSS) * HTN * CE_DIV + VSS * HTP * CE_DIV));

    // Step 4: 1000-cycle pause mid-line stretches the PAL frame by exactly 1000.
    repeat (200) @(posedge clk32);
    #1;
    pause = 1'b1;
    @(posedge clk32); #1;
    snap = obs_vec;
    repeat (999) @(posedge clk32);
    #1;
    check("pause_ce", 32'(ce_pix), 32'd0);
    check("pause_frozen", 32'(obs_vec), 32'(snap));
    pause = 1'b0;
    wait_edge(S_VSYNC, 1'b1, 20000, "vsync_after_pause");
    t_c = cyc;
    check("pause_frame_len", t_c - t_b, 32'(VTP * HTP * CE_DIV + 1000));

    // Step 5: back to NTSC with interlace requested.
    @(posedge clk32); #1;
    ntsc = 1'b1;
    ilace = 1'b1;
    wait_edge(S_VSYNC, 1'b1, 20000, "vsync_ilace_a");
    t_v = cyc;
    check("field_first", 32'(field), 32'(IL_EN));
    check("ilace_out", 32'(ilace_out), 32'(IL_EN));
    wait_edge(S_HBLANK, 1'b0, 2000, "line_start");
    t_n = cyc;
    check("vsync_offset", t_v + HTN * CE_DIV - t_n, 32'(IL_EN * (HTN / 2) * CE_DIV));
    wait_edge(S_VSYNC, 1'b1, 20000, "vsync_ilace_b");
    t_w = cyc;
    check("frame_ilace", t_w - t_v,
          32'(IL_EN ? ((VTN - 1) * HTN - HTN / 2) * CE_DIV : VTN * HTN * CE_DIV));
    check("field_second", 32'(field), 32'd0);

    // Step 6: colour bars in an active line, then horizontal blanking.
    wait_edge(S_VBLANK, 1'b0, 20000, "frame_top");
    check("bar_px0", 32'({hblank, vblank, r, g, b}), 32'd0);
    repeat (4 * 64) @(negedge clk32);
    check("bar_px64", 32'({hblank, r, g, b}), 32'h0_0000FF);
    repeat (4 * 36) @(negedge clk32);
    check("bar_px100", 32'({hblank, r, g, b}), 32'h0_0000FF);
    repeat (4 * 30) @(negedge clk32);
    check("bar_px130", 32'({hblank, r, g, b}), 32'h0_00FF00);
    repeat (4 * 6) @(negedge clk32);
    check("bar_px136_blank", 32'({hblank, r, g, b}), 32'h1_000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
